// File: rtl/aes_io_pkg.sv
// Shared definitions for the AES input-side loaders: loader states, block/iteration defaults
// and the BCD digit helpers.
package aes_io_pkg;

    localparam int NBYTES_DEF = 16;
    localparam int ITER_DEF   = 10;
    localparam int BCD_W      = 4;
    localparam int MAX_BYTE   = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        STORE = 2'd2,
        FULL  = 2'd3
    } state_t;

    function automatic logic digit_bad(input logic [BCD_W-1:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_block_loader_if.sv
// Entry and block handshakes between the digit source, bcd_block_loader and the cipher.
// The master modport is the source/consumer side and the slave modport is the loader.
interface bcd_block_loader_if
    import aes_io_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
);
    localparam int CW = $clog2(NBYTES + 1);

    logic                  bcd_valid;
    logic                  bcd_ready;
    logic [BCD_W-1:0]      hundreds;
    logic [BCD_W-1:0]      tens;
    logic [BCD_W-1:0]      units;
    logic [0:8*NBYTES-1]   block_out;
    logic                  block_valid;
    logic                  block_ready;
    logic                  err;
    logic [CW-1:0]         byte_count;

    modport master (
        output bcd_valid, hundreds, tens, units, block_ready,
        input  bcd_ready, block_out, block_valid, err, byte_count
    );

    modport slave (
        input  bcd_valid, hundreds, tens, units, block_ready,
        output bcd_ready, block_out, block_valid, err, byte_count
    );

endinterface

// File: rtl/bcd_rdd_step.sv
// One reverse double-dabble iteration: shift right by one, then take 3 from every BCD nibble
// that reads 8 or more (4-bit subtract, no borrow between nibbles).
module bcd_rdd_step
    import aes_io_pkg::*;
#(
    parameter int ITER = ITER_DEF
) (
    input  logic [3*BCD_W+ITER-1:0] d,
    output logic [3*BCD_W+ITER-1:0] q
);

    logic [3*BCD_W+ITER-1:0] s;

    always_comb begin
        s = d >> 1;
        for (int i = 0; i < 3; i++) begin
            if (s[ITER+BCD_W*i +: BCD_W] >= 4'd8)
                s[ITER+BCD_W*i +: BCD_W] = s[ITER+BCD_W*i +: BCD_W] - 4'd3;
        end
        q = s;
    end

endmodule

// File: rtl/bcd_block_loader.sv
// Converts three-digit BCD entries to bytes and packs them MSB-first into an AES input block.
// Optional synchronous abort port when BCD_LOADER_ABORT_EN is defined.
module bcd_block_loader
    import aes_io_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF,
    parameter int ITER   = ITER_DEF
) (
    input  logic clk,
    input  logic rst,
`ifdef BCD_LOADER_ABORT_EN
    input  logic abort,
`endif
    bcd_block_loader_if.slave bus
);

    localparam int CW   = $clog2(NBYTES + 1);
    localparam int IW   = $clog2(ITER + 1);
    localparam int SR_W = 3*BCD_W + ITER;

    state_t              state;
    logic [SR_W-1:0]     sr;
    logic [SR_W-1:0]     step_q;
    logic [IW-1:0]       iter_cnt;
    logic [CW-1:0]       byte_cnt;
    logic [0:8*NBYTES-1] blk;
    logic                bcd_ready_r;
    logic                block_valid_r;
    logic                err_r;

    function automatic logic over_range(input logic [ITER-1:0] v);
        return int'(v) > MAX_BYTE;
    endfunction

    bcd_rdd_step #(.ITER(ITER)) u_step (
        .d (sr),
        .q (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            sr            <= '0;
            iter_cnt      <= '0;
            byte_cnt      <= '0;
            blk           <= '0;
            bcd_ready_r   <= 1'b1;
            block_valid_r <= 1'b0;
            err_r         <= 1'b0;
        end
`ifdef BCD_LOADER_ABORT_EN
        else if (abort) begin
            state         <= IDLE;
            sr            <= '0;
            iter_cnt      <= '0;
            byte_cnt      <= '0;
            bcd_ready_r   <= 1'b1;
            block_valid_r <= 1'b0;
            err_r         <= 1'b0;
        end
`endif
        else begin
            err_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.bcd_valid && bcd_ready_r) begin
                        if (digit_bad(bus.hundreds) || digit_bad(bus.tens) || digit_bad(bus.units)) begin
                            err_r <= 1'b1;
                        end else begin
                            sr          <= {bus.hundreds, bus.tens, bus.units, {ITER{1'b0}}};
                            iter_cnt    <= '0;
                            bcd_ready_r <= 1'b0;
                            state       <= CONV;
                        end
                    end
                end
                CONV: begin
                    sr       <= step_q;
                    iter_cnt <= iter_cnt + IW'(1);
                    // Flag the range error on the last shift so err lines up with STORE.
                    if (iter_cnt == IW'(ITER-1)) begin
                        err_r <= over_range(step_q[ITER-1:0]);
                        state <= STORE;
                    end
                end
                STORE: begin
                    if (over_range(sr[ITER-1:0])) begin
                        bcd_ready_r <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        blk[8*byte_cnt +: 8] <= sr[7:0];
                        byte_cnt             <= byte_cnt + CW'(1);
                        if (byte_cnt == CW'(NBYTES-1)) begin
                            block_valid_r <= 1'b1;
                            state         <= FULL;
                        end else begin
                            bcd_ready_r <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                FULL: begin
                    if (block_valid_r && bus.block_ready) begin
                        byte_cnt      <= '0;
                        block_valid_r <= 1'b0;
                        bcd_ready_r   <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bcd_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.bcd_ready   = bcd_ready_r;
    assign bus.block_valid = block_valid_r;
    assign bus.block_out   = blk;
    assign bus.err         = err_r;
    assign bus.byte_count  = byte_cnt;

endmodule

// File: tb/tb_bcd_block_loader.sv
// Directed bench for bcd_block_loader: conversion latency, packing, range/digit errors,
// full-block backpressure, asynchronous reset and (with BCD_LOADER_ABORT_EN) abort.
module tb_bcd_block_loader;
    import aes_io_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef BCD_LOADER_ABORT_EN
    logic abort = 1'b0;
`endif

    bcd_block_loader_if #(.NBYTES(16)) bus ();

    bcd_block_loader #(.NBYTES(16), .ITER(10)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef BCD_LOADER_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers one entry for a single edge, then waits (bounded) until the loader is ready again
    // or presents a full block. lat counts negedges spent not ready; errs counts err-high samples.
    task automatic send(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                        output int lat, output int errs);
        bus.hundreds  = h;
        bus.tens      = t;
        bus.units     = u;
        bus.bcd_valid = 1'b1;
        @(negedge clk);
        bus.bcd_valid = 1'b0;
        lat  = 0;
        errs = 0;
        while (!bus.bcd_ready && !bus.block_valid && lat < 40) begin
            if (bus.err) errs++;
            lat++;
            @(negedge clk);
        end
        if (bus.err) errs++;
    endtask

    int lat, errs, v, stable, errs_full;
    logic [127:0] exp_blk;
    logic [127:0] snap;

    initial begin
        bus.bcd_valid   = 1'b0;
        bus.hundreds    = '0;
        bus.tens        = '0;
        bus.units       = '0;
        bus.block_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_bcd_ready",   bus.bcd_ready,   1);
        chk("rst_block_valid", bus.block_valid, 0);
        chk("rst_err",         bus.err,         0);
        chk("rst_byte_count",  bus.byte_count,  0);
        chk("rst_block_out",   bus.block_out,   0);
        rst = 1'b0;
        @(negedge clk);

        // Single entry 255
        send(4'd2, 4'd5, 4'd5, lat, errs);
        chk("e255_latency",    lat, 11);
        chk("e255_err",        errs, 0);
        chk("e255_byte_count", bus.byte_count, 1);
        chk("e255_slot0",      bus.block_out[0:7], 8'hFF);

        // 0 then 128 into a fresh block
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(4'd0, 4'd0, 4'd0, lat, errs);
        send(4'd1, 4'd2, 4'd8, lat, errs);
        chk("e128_byte_count", bus.byte_count, 2);
        chk("e0_e128_slots",   bus.block_out[0:15], 16'h0080);
        chk("e128_err",        errs, 0);

        // Range errors
        send(4'd2, 4'd5, 4'd6, lat, errs);
        chk("e256_err_pulse",  errs, 1);
        chk("e256_latency",    lat, 11);
        chk("e256_byte_count", bus.byte_count, 2);
        send(4'd9, 4'd9, 4'd9, lat, errs);
        chk("e999_err_pulse",  errs, 1);
        chk("e999_byte_count", bus.byte_count, 2);
        chk("e999_slots_kept", bus.block_out[0:15], 16'h0080);

        // Digit error
        send(4'd0, 4'd10, 4'd0, lat, errs);
        chk("dig_latency",   lat, 0);
        chk("dig_err_n1",    bus.err, 1);
        chk("dig_ready_n1",  bus.bcd_ready, 1);
        @(negedge clk);
        chk("dig_err_n2",    bus.err, 0);
        chk("dig_ready_n2",  bus.bcd_ready, 1);
        chk("dig_byte_count", bus.byte_count, 2);

        // Full block 0,17,...,255
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        errs_full = 0;
        for (int i = 0; i < 16; i++) begin
            v = 17 * i;
            send(4'(v / 100), 4'((v / 10) % 10), 4'(v % 10), lat, errs);
            errs_full += errs;
        end
        exp_blk = 128'h00112233445566778899aabbccddeeff;
        chk("full_latency",     lat, 11);
        chk("full_err",         errs_full, 0);
        chk("full_block_valid", bus.block_valid, 1);
        chk("full_block_out",   bus.block_out, exp_blk);
        chk("full_byte_count",  bus.byte_count, 16);

        // Backpressure with an entry offered meanwhile
        snap   = bus.block_out;
        stable = 0;
        bus.hundreds  = 4'd0;
        bus.tens      = 4'd0;
        bus.units     = 4'd1;
        bus.bcd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.block_out === snap && bus.bcd_ready === 1'b0 && bus.block_valid === 1'b1)
                stable++;
        end
        chk("bp_stable_cycles", stable, 5);
        chk("bp_byte_count",    bus.byte_count, 16);
        bus.bcd_valid   = 1'b0;
        bus.block_ready = 1'b1;
        @(negedge clk);
        bus.block_ready = 1'b0;
        chk("take_block_valid", bus.block_valid, 0);
        chk("take_bcd_ready",   bus.bcd_ready, 1);
        chk("take_byte_count",  bus.byte_count, 0);
        chk("take_block_kept",  bus.block_out, exp_blk);

        // Reset in the middle of a conversion
        bus.hundreds  = 4'd1;
        bus.tens      = 4'd2;
        bus.units     = 4'd3;
        bus.bcd_valid = 1'b1;
        @(negedge clk);
        bus.bcd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midconv_ready_low", bus.bcd_ready, 0);
        rst = 1'b1;
        #1;
        chk("midrst_bcd_ready",   bus.bcd_ready, 1);
        chk("midrst_block_valid", bus.block_valid, 0);
        chk("midrst_err",         bus.err, 0);
        chk("midrst_byte_count",  bus.byte_count, 0);
        chk("midrst_block_out",   bus.block_out, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef BCD_LOADER_ABORT_EN
        // Abort after seven stored bytes
        for (int i = 0; i < 7; i++) begin
            send(4'd0, 4'd0, 4'(i + 1), lat, errs);
        end
        chk("abort_pre_count", bus.byte_count, 7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_byte_count", bus.byte_count, 0);
        chk("abort_bcd_ready",  bus.bcd_ready, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_block_loader.md
# bcd_block_loader

Converts three-digit decimal (BCD) byte entries into binary bytes and packs them into a 128-bit AES input block. It is the input-side counterpart of the binary-to-BCD display path. Operator or host digits enter through a valid/ready handshake. Each entry is converted by sequential reverse double-dabble, range-checked, and appended to the block. A full block is presented to the cipher on a second valid/ready handshake.

## Interface
- NBYTES, 16: bytes per block; block_out width is 8*NBYTES.
- ITER, 10: reverse double-dabble iterations, one per bit of the 10-bit intermediate (0..999).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- bcd_valid  in  1  entry offered.
- bcd_ready  out  1  loader accepts an entry this cycle.
- hundreds  in  4  BCD hundreds digit.
- tens  in  4  BCD tens digit.
- units  in  4  BCD units digit.
- block_out  out  8*NBYTES  packed block, bit 0 is the MSB; the first accepted byte is in [0:7].
- block_valid  out  1  block_out is complete.
- block_ready  in  1  consumer takes the block.
- err  out  1  one-cycle pulse when an entry is rejected.
- byte_count  out  $clog2(NBYTES+1)  bytes stored in the current block.

## Operation
- States:
  - IDLE: bcd_ready=1.
  - CONV: runs ITER cycles.
  - STORE: 1 cycle.
  - FULL: block_valid=1.
- IDLE:
  - Acceptance is bcd_valid && bcd_ready.
  - Digit check on accept: if any digit is >9, pulse err next cycle, discard the entry, stay in IDLE.
  - Otherwise load the 22-bit shift register {hundreds, tens, units, 10'b0} and go to CONV.
- CONV, each iteration:
  - Shift the whole register right by 1.
  - Then, for each of the 3 BCD nibbles, if the nibble is >=8, subtract 3.
  - After ITER iterations the low 10 bits hold the binary value.
- STORE:
  - If value >255: pulse err, discard, return to IDLE; byte_count is unchanged.
  - Otherwise write value[7:0] to byte slot byte_count and increment byte_count.
  - If byte_count reaches NBYTES, go to FULL; else return to IDLE.
- FULL:
  - Hold block_out and block_valid until block_ready.
  - On block_valid && block_ready: clear byte_count, return to IDLE.
  - block_out keeps its last contents until overwritten slot by slot.
- bcd_ready is 0 in CONV, STORE and FULL; entries offered there are not consumed.
- Arithmetic: nibble subtract is 4-bit, with no borrow across nibbles. The hundreds digit is not range-limited before conversion, so 0..999 are all convertible and >255 is caught in STORE.

## Timing
- Reset values:
  - State IDLE.
  - bcd_ready=1.
  - block_valid=0.
  - block_out=0.
  - err=0.
  - byte_count=0.
  - Shift register 0.
- Entry accepted at edge N:
  - CONV occupies cycles N+1..N+ITER.
  - STORE is at N+ITER+1.
  - bcd_ready rises, or block_valid rises on the last byte, at N+ITER+2 (N+12 by default).
- Rejected digit: err high in cycle N+1 only; bcd_ready stays 1, so back-to-back entries are allowed.
- Range error: err high during the STORE cycle.
- block_ready asserted in the same cycle block_valid rises: the block is consumed and bcd_ready=1 on the next cycle.
- rst mid-CONV or mid-FULL: immediate return to reset values, and the partial block is lost.

## Configuration
- BCD_LOADER_ABORT_EN defined:
  - Adds port abort (in, 1), synchronous.
  - From any state, abort=1 forces IDLE, clears byte_count and the shift register, and suppresses any pending err.
  - Abort takes priority over a simultaneous bcd accept or block handshake.
- Not defined: the port is absent and there is no abort path.

## Structure
- Shared package aes_io_pkg holds:
  - The state enum (IDLE, CONV, STORE, FULL).
  - The NBYTES and ITER defaults.
  - The BCD digit width (4).
  - The max byte value (255).
- One combinational sub-module, bcd_rdd_step: a single reverse double-dabble iteration (22-bit in, 22-bit out), instantiated once and applied every CONV cycle.

## Test plan
- Single entry 2,5,5:
  - bcd_ready low for 11 cycles, then back high at N+12.
  - byte_count=1, block_out[0:7]=8'hFF, err never high.
- Entry 0,0,0 then 1,2,8: slots 0 and 1 = 8'h00 and 8'h80; byte_count=2.
- Range error:
  - Entry 2,5,6: err pulse in STORE, byte_count unchanged.
  - Entry 9,9,9: likewise rejected.
- Digit error: entry 0,10,0: err at N+1, bcd_ready stays 1, no CONV entered.
- Full block and backpressure:
  - 16 entries 0,17,34,…,255 (as BCD) → block_out=128'h00112233445566778899aabbccddeeff, block_valid=1.
  - Hold block_ready=0 for 5 cycles: block_out stable and bcd_ready=0 throughout.
  - Then block_ready=1: byte_count=0 and bcd_ready=1 next cycle.
- Reset mid-CONV at iteration 4: all outputs return to reset values immediately.
- With BCD_LOADER_ABORT_EN, abort after 7 bytes: byte_count=0 next cycle.
